// File: rtl/rom_port_pkg.sv
// Shared types and constants for the ROM port responder and its request FIFO.
package rom_port_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  // Address field is sized for the widest supported AW; the top truncates on the way out.
  typedef struct packed {
    logic [ADDR_MAX_W-1:0] a;
    logic [1:0]            ds;
    logic                  we;
    logic [DATA_W-1:0]     d;
  } req_t;

endpackage

// File: rtl/rom_port_fifo.sv
// In-order request queue: DEPTH-entry circular buffer of req_t with an occupancy count.
module rom_port_fifo
  import rom_port_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  req_t          i_wdata,
  output req_t          o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  req_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Storage, pointers and occupancy; a push to a full queue is only legal alongside a pop.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (i_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign o_count = r_count;

endmodule

// File: rtl/rom_port_responder.sv
// Toggle-handshake initiator port queued onto a level-request / one-cycle-grant memory slot,
// one access in flight, completions acknowledged by toggling port_ack.
module rom_port_responder
  import rom_port_pkg::*;
#(
  parameter int AW    = 23,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              port_req,
  output logic              port_ack,
  input  logic [AW-1:0]     port_a,
  input  logic [1:0]        port_ds,
  input  logic              port_we,
  input  logic [DATA_W-1:0] port_d,
  output logic [DATA_W-1:0] port_q,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [AW-1:0]     mem_a,
  output logic [1:0]        mem_ds,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_q_valid,
  output logic              busy,
  output logic              overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_armed;
  logic              r_req_seen;
  logic              r_drop_pend;
  logic              r_ack;
  logic              r_overflow;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [AW-1:0]     r_mem_a;
  logic [1:0]        r_mem_ds;
  logic [DATA_W-1:0] r_mem_d;
  logic [DATA_W-1:0] r_port_q;

  req_t              w_push_rec;
  req_t              w_head;
  logic              w_req_det;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_gnt_taken;
  logic              w_rd_done;
  logic              w_done;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;

  // Requests are ignored until init_n has been high for a full cycle (r_armed).
  assign w_req_det   = r_armed & (port_req ^ r_req_seen);
  assign w_pop       = (r_state == IDLE) & ~w_empty;
  assign w_push      = w_req_det & (~w_full | w_pop);
  assign w_drop      = w_req_det & w_full & ~w_pop;
  assign w_gnt_taken = (r_state == ISSUE) & mem_gnt;
  assign w_rd_done   = (r_state == RDWAIT) & mem_q_valid;
  assign w_done      = (w_gnt_taken & r_mem_we) | w_rd_done;
  assign w_push_rec  = '{a: ADDR_MAX_W'(port_a), ds: port_ds, we: port_we, d: port_d};

  rom_port_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .init_n  (init_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_rec),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Access sequencer next state; mem_gnt and mem_q_valid only matter in their own state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = ISSUE;
        else          w_state_nxt = IDLE;
      end
      ISSUE: begin
        if (mem_gnt) w_state_nxt = r_mem_we ? IDLE : RDWAIT;
        else         w_state_nxt = ISSUE;
      end
      RDWAIT: begin
        if (mem_q_valid) w_state_nxt = IDLE;
        else             w_state_nxt = RDWAIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake bookkeeping; a drop ack and a completion ack in the same edge cancel.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_req_seen  <= 1'b0;
      r_drop_pend <= 1'b0;
      r_ack       <= 1'b0;
      r_overflow  <= 1'b0;
      r_port_q    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_armed     <= 1'b1;
      r_drop_pend <= w_drop;
      r_overflow  <= r_overflow | w_drop;
      r_ack       <= r_ack ^ r_drop_pend ^ w_done;
      if (w_req_det) begin
        r_req_seen <= port_req;
      end
      if (w_rd_done) begin
        r_port_q <= mem_q;
      end
    end
  end

  // Memory command registers: loaded on pop, held through ISSUE, request dropped after grant.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_a   <= '0;
      r_mem_ds  <= 2'b00;
      r_mem_d   <= '0;
    end else if (w_pop) begin
      r_mem_req <= 1'b1;
      r_mem_we  <= w_head.we;
      r_mem_a   <= AW'(w_head.a);
      r_mem_ds  <= w_head.ds;
      r_mem_d   <= w_head.d;
    end else if (w_gnt_taken) begin
      r_mem_req <= 1'b0;
    end
  end

  assign port_ack = r_ack;
  assign port_q   = r_port_q;
  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_a    = r_mem_a;
  assign mem_ds   = r_mem_ds;
  assign mem_d    = r_mem_d;
  assign overflow = r_overflow;
  assign busy     = (w_count != CW'(0)) | (r_state != IDLE);

endmodule

// File: tb/tb_rom_port_responder.sv
// Directed bench for rom_port_responder: a queue-level model checked every cycle,
// plus hand-computed expectations for write, read, burst, overflow and reset scenarios.
module tb_rom_port_responder;

  localparam int AW    = 23;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          init_n;
  logic          port_req = 1'b0;
  logic [AW-1:0] port_a = '0;
  logic [1:0]    port_ds = 2'b00;
  logic          port_we = 1'b0;
  logic [15:0]   port_d = 16'h0000;
  logic          mem_gnt = 1'b0;
  logic [15:0]   mem_q = 16'h0000;
  logic          mem_q_valid = 1'b0;
  logic          port_ack;
  logic [15:0]   port_q;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [1:0]    mem_ds;
  logic [15:0]   mem_d;
  logic          busy;
  logic          overflow;

  always #5 clk = ~clk;

  rom_port_responder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .init_n(init_n), .port_req(port_req), .port_ack(port_ack),
    .port_a(port_a), .port_ds(port_ds), .port_we(port_we), .port_d(port_d), .port_q(port_q),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_d(mem_d), .mem_q(mem_q), .mem_q_valid(mem_q_valid), .busy(busy), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: request queue + current access ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic          we;
    logic [15:0]   d;
  } mreq_t;

  mreq_t       m_q[$];
  mreq_t       m_cur = '{a: '0, ds: 2'b00, we: 1'b0, d: 16'h0000};
  mreq_t       m_new;
  int          m_phase = 0;   // 0: nothing in flight, 1: awaiting grant, 2: awaiting read data
  int          m_pre;
  bit          m_pop_now, m_newreq, m_toggle;
  logic        m_seen = 1'b0, m_armed = 1'b0, m_ack = 1'b0, m_ovf = 1'b0, m_drop_pend = 1'b0;
  logic [15:0] m_data = 16'h0000;

  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      m_q.delete();
      m_phase = 0; m_seen = 1'b0; m_armed = 1'b0; m_ack = 1'b0;
      m_ovf = 1'b0; m_drop_pend = 1'b0; m_data = 16'h0000;
      m_cur = '{a: '0, ds: 2'b00, we: 1'b0, d: 16'h0000};
    end else begin
      m_toggle    = m_drop_pend;
      m_drop_pend = 1'b0;
      m_pre       = m_phase;
      m_pop_now   = (m_pre == 0) && (m_q.size() > 0);
      m_newreq    = m_armed && (port_req != m_seen);
      if (m_newreq) begin
        m_seen = port_req;
        m_new  = '{a: port_a, ds: port_ds, we: port_we, d: port_d};
      end
      if (m_pre == 1 && mem_gnt) begin
        if (m_cur.we) begin m_phase = 0; m_toggle = ~m_toggle; end
        else          m_phase = 2;
      end else if (m_pre == 2 && mem_q_valid) begin
        m_data = mem_q; m_phase = 0; m_toggle = ~m_toggle;
      end
      if (m_newreq && !(m_q.size() < DEPTH || m_pop_now)) begin
        m_ovf = 1'b1; m_drop_pend = 1'b1;
      end
      if (m_pop_now) begin
        m_cur = m_q.pop_front(); m_phase = 1;
      end
      if (m_newreq && !m_drop_pend) m_q.push_back(m_new);
      m_ack   = m_ack ^ m_toggle;
      m_armed = 1'b1;
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  logic [AW-1:0] got_a[$];
  int            n_gnt = 0;

  always @(negedge clk) begin
    chk("ack", port_ack, m_ack);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, (m_q.size() > 0 || m_phase != 0));
    chk("mem_req", mem_req, (m_phase == 1));
    chk("port_q", port_q, m_data);
    if (m_phase == 1) begin
      chk("cmd_a", mem_a, m_cur.a);
      chk("cmd_ds", mem_ds, m_cur.ds);
      chk("cmd_we", mem_we, m_cur.we);
      chk("cmd_d", mem_d, m_cur.d);
    end
    if (mem_req && mem_gnt) begin
      got_a.push_back(mem_a);
      n_gnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    init_n = 1'b0; port_req = 1'b0; mem_gnt = 1'b0; mem_q_valid = 1'b0;
    tick(); tick();
    init_n = 1'b1;
    tick();
  endtask

  task automatic grant_all();
    int n = 0;
    do begin
      tick();
      if (mem_gnt)      mem_gnt = 1'b0;
      else if (mem_req) mem_gnt = 1'b1;
      n++;
    end while ((busy || mem_gnt) && n < 200);
    chk("grant_all_drained", {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] exp_burst [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h200};

  initial begin
    init_n = 1'b0;
    tick(); tick();
    chk("rst_ack", port_ack, 0); chk("rst_busy", busy, 0); chk("rst_mem_req", mem_req, 0);
    chk("rst_q", port_q, 0); chk("rst_ovf", overflow, 0);
    init_n = 1'b1;
    tick();

    // stray read data while idle
    mem_q = 16'h5555; mem_q_valid = 1'b1; tick(); mem_q_valid = 1'b0;
    chk("stray_idle_q", port_q, 0);

    // single write, grant in first ISSUE cycle
    port_a = 23'h10; port_ds = 2'b01; port_we = 1'b1; port_d = 16'h00A5; port_req = 1'b1;
    tick(); tick();
    chk("wr_mem_req", mem_req, 1); chk("wr_mem_a", mem_a, 32'h10); chk("wr_mem_ds", mem_ds, 32'h1);
    chk("wr_mem_we", mem_we, 1); chk("wr_mem_d", mem_d, 32'hA5); chk("wr_ack_early", port_ack, 0);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    chk("wr_ack", port_ack, 1); chk("wr_mem_req_drop", mem_req, 0); chk("wr_busy", busy, 0);

    // single read; stray valid during ISSUE and stray grant during RDWAIT are ignored
    port_a = 23'h10000; port_ds = 2'b11; port_we = 1'b0; port_d = 16'h0000; port_req = 1'b0;
    tick(); tick();
    mem_gnt = 1'b1; mem_q = 16'h1234; mem_q_valid = 1'b1;
    tick(); mem_q_valid = 1'b0;
    chk("rd_q_ignored", port_q, 0); chk("rd_ack_wait", port_ack, 1);
    tick(); mem_gnt = 1'b0;
    mem_q = 16'hBEEF; mem_q_valid = 1'b1;
    tick(); mem_q_valid = 1'b0;
    chk("rd_q", port_q, 32'hBEEF); chk("rd_ack", port_ack, 0); chk("rd_busy", busy, 0);

    // burst of 5 with grant withheld, then a push into the full queue alongside the idle pop
    got_a.delete(); n_gnt = 0;
    port_we = 1'b1; port_ds = 2'b11;
    for (int i = 0; i < 5; i++) begin
      port_req = ~port_req; port_a = AW'(32'h100 + i); port_d = 16'(i); tick();
    end
    tick(); tick();
    chk("burst_ovf", overflow, 0); chk("burst_mem_req", mem_req, 1);
    chk("burst_head", mem_a, 32'h100); chk("burst_busy", busy, 1);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    port_req = ~port_req; port_a = 23'h200; port_d = 16'h0200; tick();
    chk("simul_ovf", overflow, 0);
    grant_all();
    chk("burst_ngnt", n_gnt, 6);
    for (int i = 0; i < 6; i++) chk("burst_order", (i < got_a.size()) ? 32'(got_a[i]) : 32'hFFFF_FFFF, exp_burst[i]);
    chk("burst_parity", port_ack, port_req); chk("burst_ovf_end", overflow, 0);

    // overflow: 6 toggles, grant withheld -> the sixth is dropped
    do_reset();
    got_a.delete(); n_gnt = 0;
    for (int i = 0; i < 6; i++) begin
      port_req = ~port_req; port_a = AW'(32'h300 + i); port_d = 16'(32'h30 + i); tick();
    end
    tick(); tick();
    chk("ovf_flag", overflow, 1);
    grant_all();
    chk("ovf_ngnt", n_gnt, 5);
    for (int i = 0; i < 5; i++) chk("ovf_order", (i < got_a.size()) ? 32'(got_a[i]) : 32'hFFFF_FFFF, 32'h300 + i);
    chk("ovf_parity", port_ack, port_req); chk("ovf_sticky", overflow, 1);

    // reset while waiting for read data with a write still queued
    port_we = 1'b0; port_a = 23'h4321; port_ds = 2'b11; port_d = 16'h1357; port_req = ~port_req;
    tick();
    port_we = 1'b1; port_a = 23'h0777; port_ds = 2'b10; port_d = 16'h9999; port_req = ~port_req;
    tick();
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #1 init_n = 1'b0; port_req = 1'b0;
    #1;
    chk("arst_ack", port_ack, 0); chk("arst_q", port_q, 0); chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_we", mem_we, 0); chk("arst_mem_a", mem_a, 0); chk("arst_mem_ds", mem_ds, 0);
    chk("arst_mem_d", mem_d, 0); chk("arst_busy", busy, 0); chk("arst_ovf", overflow, 0);
    tick(); init_n = 1'b1; tick();
    mem_q = 16'hDEAD; mem_q_valid = 1'b1; tick(); mem_q_valid = 1'b0;
    tick(); tick();
    chk("post_rst_q", port_q, 0); chk("post_rst_ack", port_ack, 0);
    chk("post_rst_busy", busy, 0); chk("post_rst_mem_req", mem_req, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
